// File: rtl/opb_reg_bank_ppc2simulink.sv
// OPB slave register bank: NUM_REGS software-writable 32-bit control
// registers plus NUM_STATUS read-only status words from the user fabric.
// Control writes honour byte enables and raise a one-cycle write strobe for
// the addressed register. Registers flagged in PULSE_MASK clear themselves
// after the strobe cycle, which makes them usable as start/arm triggers.
// Each bus transfer takes three cycles: IDLE (capture), ACK and GAP. The GAP
// cycle absorbs an OPB_select that lingers for one cycle after the ack.
// All logic runs on OPB_Clk, and OPB_Rst is a synchronous active-high reset.

module opb_reg_bank_ppc2simulink #(
    parameter logic [31:0] C_BASEADDR   = 32'h010B2100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010B21FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter              C_FAMILY     = "virtex5",
    parameter int          NUM_REGS     = 4,
    parameter int          NUM_STATUS   = 2,
    parameter logic [15:0] PULSE_MASK   = 16'h0000
) (
    input  logic                                            OPB_Clk,
    input  logic                                            OPB_Rst,
    input  logic [0:31]                                     OPB_ABus,
    input  logic [0:3]                                      OPB_BE,
    input  logic [0:31]                                     OPB_DBus,
    input  logic                                            OPB_RNW,
    input  logic                                            OPB_select,
    input  logic                                            OPB_seqAddr,
    output logic [0:31]                                     Sl_DBus,
    output logic                                            Sl_xferAck,
    output logic                                            Sl_errAck,
    output logic                                            Sl_retry,
    output logic                                            Sl_toutSup,
    output logic [NUM_REGS*32-1:0]                          user_data_out,
    output logic [NUM_REGS-1:0]                             user_wr_strobe,
    input  logic [((NUM_STATUS > 0) ? NUM_STATUS : 1)*32-1:0] user_status_in
);

    // Status words start at byte offset 0x40, which is word index 16.
    localparam int STATUS_WORD0 = 16;

    // Configuration values that only describe the bus or the target family.
    localparam int   FAMILY_BITS = $bits(C_FAMILY);
    localparam logic CFG_OK_S    = (C_OPB_AWIDTH == 32) && (C_OPB_DWIDTH == 32) && (FAMILY_BITS > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Returns old_v with each byte k replaced by new_v's byte k when be[k]=1.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        for (int k = 0; k < 4; k++) begin
            res[8*k +: 8] = be[k] ? new_v[8*k +: 8] : old_v[8*k +: 8];
        end
        return res;
    endfunction

    state_t        state_r;
    state_t        state_nxt_s;

    logic [31:0]   addr_s;
    logic [5:0]    word_s;
    logic          hit_s;
    logic [31:0]   rd_data_s;
    logic          wr_apply_s;

    logic          rnw_r;
    logic [5:0]    word_r;
    logic [3:0]    be_r;
    logic [31:0]   wdata_r;
    logic [31:0]   sl_dbus_r;
    logic          xfer_ack_r;

    logic [31:0]   ctrl_r [NUM_REGS];
    logic [NUM_REGS-1:0] strobe_r;

    logic          unused_s;

    // Bus bit 0 is the MSB, so whole-vector copies put OPB bit k on user bit
    // 31-k. OPB_BE[0] lands on bit 3 and therefore covers user byte 3.
    assign addr_s = OPB_ABus;
    assign word_s = OPB_ABus[24:29];
    assign hit_s  = OPB_select && (addr_s >= C_BASEADDR) && (addr_s <= C_HIGHADDR);

    // A write lands in the ACK cycle and is committed at the edge that ends it.
    assign wr_apply_s = (state_r == ST_ACK) && !rnw_r;

    assign Sl_DBus        = sl_dbus_r;
    assign Sl_xferAck     = xfer_ack_r;
    assign Sl_errAck      = 1'b0;
    assign Sl_retry       = 1'b0;
    assign Sl_toutSup     = 1'b0;
    assign user_wr_strobe = strobe_r;

    assign unused_s = ^{1'b0, OPB_seqAddr, CFG_OK_S, user_status_in};

    // Transfer state register.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a hit is only accepted in IDLE, so a select held into GAP is ignored.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (hit_s) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK:  state_nxt_s = ST_GAP;
            ST_GAP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Read mux: control registers at words 0.., status at words 16..; other words read 0.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (word_s == 6'(i)) begin
                rd_data_s = ctrl_r[i];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
        for (int j = 0; j < NUM_STATUS; j++) begin
            if (word_s == 6'(STATUS_WORD0 + j)) begin
                rd_data_s = user_status_in[32*j +: 32];
            end else begin
                rd_data_s = rd_data_s;
            end
        end
    end

    // Capture the request on an IDLE hit and drive the ack and read data for the ACK cycle.
    always_ff @(posedge OPB_Clk) begin
        if (OPB_Rst) begin
            rnw_r      <= 1'b1;
            word_r     <= 6'd0;
            be_r       <= 4'h0;
            wdata_r    <= 32'h0000_0000;
            sl_dbus_r  <= 32'h0000_0000;
            xfer_ack_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (hit_s) begin
                        rnw_r      <= OPB_RNW;
                        word_r     <= word_s;
                        be_r       <= OPB_BE;
                        wdata_r    <= OPB_DBus;
                        xfer_ack_r <= 1'b1;
                        sl_dbus_r  <= OPB_RNW ? rd_data_s : 32'h0000_0000;
                    end else begin
                        xfer_ack_r <= 1'b0;
                        sl_dbus_r  <= 32'h0000_0000;
                    end
                end
                default: begin
                    xfer_ack_r <= 1'b0;
                    sl_dbus_r  <= 32'h0000_0000;
                end
            endcase
        end
    end

    // Control registers and strobes: a write updates the enabled bytes and pulses
    // the strobe for the GAP cycle; a pulse-mode register clears on any other edge.
    always_ff @(posedge OPB_Clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            if (OPB_Rst) begin
                ctrl_r[i]   <= 32'h0000_0000;
                strobe_r[i] <= 1'b0;
            end else if (wr_apply_s && (word_r == 6'(i))) begin
                ctrl_r[i]   <= merge_bytes(ctrl_r[i], wdata_r, be_r);
                strobe_r[i] <= 1'b1;
            end else begin
                strobe_r[i] <= 1'b0;
                if (PULSE_MASK[i]) begin
                    ctrl_r[i] <= 32'h0000_0000;
                end
            end
        end
    end

    // Flatten the register array onto the user bus, with register i at bits [32*i+31:32*i].
    always_comb begin
        user_data_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            user_data_out[32*i +: 32] = ctrl_r[i];
        end
    end

endmodule

// File: tb/tb_opb_reg_bank_ppc2simulink.sv
// Directed bench for opb_reg_bank_ppc2simulink. A table of single transfers
// carries hand-computed read data, strobes and register contents. Hand-written
// sequences cover the address-window misses, a held select with back-to-back
// transfers, and a reset that arrives in the ACK cycle of a write.

module tb_opb_reg_bank_ppc2simulink;

    localparam logic [31:0]  BASE      = 32'h010B2100;
    localparam logic [127:0] PULSE_UDO = {32'hFFFF_FFFF, 96'h0};

    logic          clk;
    logic          OPB_Rst;
    logic [0:31]   OPB_ABus;
    logic [0:3]    OPB_BE;
    logic [0:31]   OPB_DBus;
    logic          OPB_RNW;
    logic          OPB_select;
    logic          OPB_seqAddr;
    logic [0:31]   Sl_DBus;
    logic          Sl_xferAck;
    logic          Sl_errAck;
    logic          Sl_retry;
    logic          Sl_toutSup;
    logic [127:0]  user_data_out;
    logic [3:0]    user_wr_strobe;
    logic [63:0]   user_status_in;

    int checks;
    int errors;
    logic mon_en;

    typedef struct {
        string       name;
        logic        rnw;
        logic [7:0]  off;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic [3:0]  exp_stb;
        logic [127:0] exp_udo;
    } vec_t;

    vec_t vecs[$];

    opb_reg_bank_ppc2simulink #(
        .C_BASEADDR (32'h010B2100),
        .C_HIGHADDR (32'h010B21FF),
        .NUM_REGS   (4),
        .NUM_STATUS (2),
        .PULSE_MASK (16'h0008)
    ) dut (
        .OPB_Clk        (clk),
        .OPB_Rst        (OPB_Rst),
        .OPB_ABus       (OPB_ABus),
        .OPB_BE         (OPB_BE),
        .OPB_DBus       (OPB_DBus),
        .OPB_RNW        (OPB_RNW),
        .OPB_select     (OPB_select),
        .OPB_seqAddr    (OPB_seqAddr),
        .Sl_DBus        (Sl_DBus),
        .Sl_xferAck     (Sl_xferAck),
        .Sl_errAck      (Sl_errAck),
        .Sl_retry       (Sl_retry),
        .Sl_toutSup     (Sl_toutSup),
        .user_data_out  (user_data_out),
        .user_wr_strobe (user_wr_strobe),
        .user_status_in (user_status_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // The tied-off responses must stay 0, and read data must stay 0 whenever there is no ack.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("tied_outputs", 128'({Sl_errAck, Sl_retry, Sl_toutSup}), 128'(3'b000));
            if (!Sl_xferAck) begin
                chk("dbus_idle_zero", 128'(Sl_DBus), 128'h0);
            end
        end
    end

    task automatic bus_idle();
        OPB_select = 1'b0;
        OPB_ABus   = 32'h0;
        OPB_BE     = 4'h0;
        OPB_DBus   = 32'h0;
        OPB_RNW    = 1'b0;
    endtask

    // Called at a negedge while the slave is in IDLE: returns the negedge count at ack (0 on timeout).
    task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, output logic [31:0] rd, output int ack_cyc);
        ack_cyc    = 0;
        rd         = 32'h0;
        OPB_ABus   = addr;
        OPB_BE     = be;
        OPB_DBus   = wd;
        OPB_RNW    = rnw;
        OPB_select = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (Sl_xferAck) begin
                ack_cyc = c;
                rd      = Sl_DBus;
                break;
            end
        end
        bus_idle();
    endtask

    task automatic add_vec(input string nm, input logic rnw, input logic [7:0] off,
                           input logic [3:0] be, input logic [31:0] wd, input logic [31:0] erd,
                           input logic [3:0] estb, input logic [127:0] eudo);
        vec_t v;
        v.name = nm; v.rnw = rnw; v.off = off; v.be = be; v.wdata = wd;
        v.exp_rd = erd; v.exp_stb = estb; v.exp_udo = eudo;
        vecs.push_back(v);
    endtask

    // Hard upper bound on the run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0]  rd;
        int           cyc;
        int           acks;
        logic [7:0]   pat;
        logic [127:0] u1, u2, u3, u4;

        checks         = 0;
        errors         = 0;
        mon_en         = 1'b0;
        OPB_seqAddr    = 1'b0;
        user_status_in = {32'h0000_CAFE, 32'h1234_5678};
        bus_idle();

        u1 = 128'h00000000_00000000_DEADBEEF_00000000;
        u2 = 128'h00000000_00000000_DEADBEEF_11223344;
        u3 = 128'h00000000_00000000_DEADBEEF_11BB33DD;
        u4 = 128'h00000001_00000000_DEADBEEF_11BB33DD;

        add_vec("rd_r0_rst",   1'b1, 8'h00, 4'hF, 32'h0,         32'h0,         4'b0000, 128'h0);
        add_vec("rd_r1_rst",   1'b1, 8'h04, 4'hF, 32'h0,         32'h0,         4'b0000, 128'h0);
        add_vec("rd_r2_rst",   1'b1, 8'h08, 4'hF, 32'h0,         32'h0,         4'b0000, 128'h0);
        add_vec("rd_r3_rst",   1'b1, 8'h0C, 4'hF, 32'h0,         32'h0,         4'b0000, 128'h0);
        add_vec("wr_r1_full",  1'b0, 8'h04, 4'hF, 32'hDEADBEEF,  32'h0,         4'b0010, u1);
        add_vec("rd_r1",       1'b1, 8'h04, 4'hF, 32'h0,         32'hDEADBEEF,  4'b0000, u1);
        add_vec("wr_r0_full",  1'b0, 8'h00, 4'hF, 32'h11223344,  32'h0,         4'b0001, u2);
        add_vec("wr_r0_be0101",1'b0, 8'h00, 4'h5, 32'hAABBCCDD,  32'h0,         4'b0001, u3);
        add_vec("rd_r0_merge", 1'b1, 8'h00, 4'hF, 32'h0,         32'h11BB33DD,  4'b0000, u3);
        add_vec("wr_r2_be0",   1'b0, 8'h08, 4'h0, 32'hFFFFFFFF,  32'h0,         4'b0100, u3);
        add_vec("rd_stat1",    1'b1, 8'h44, 4'hF, 32'h0,         32'h0000CAFE,  4'b0000, u3);
        add_vec("rd_stat0",    1'b1, 8'h40, 4'hF, 32'h0,         32'h12345678,  4'b0000, u3);
        add_vec("rd_unmapped", 1'b1, 8'h50, 4'hF, 32'h0,         32'h0,         4'b0000, u3);
        add_vec("wr_stat1",    1'b0, 8'h44, 4'hF, 32'h55555555,  32'h0,         4'b0000, u3);
        add_vec("wr_r3_pulse", 1'b0, 8'h0C, 4'hF, 32'h00000001,  32'h0,         4'b1000, u4);
        add_vec("rd_r3_pulse", 1'b1, 8'h0C, 4'hF, 32'h0,         32'h0,         4'b0000, u3);
        add_vec("wr_word15",   1'b0, 8'h3C, 4'hF, 32'h77777777,  32'h0,         4'b0000, u3);
        add_vec("rd_top_word", 1'b1, 8'hFC, 4'hF, 32'h0,         32'h0,         4'b0000, u3);

        // Reset state.
        OPB_Rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ack",    128'(Sl_xferAck), 128'h0);
        chk("rst_dbus",   128'(Sl_DBus), 128'h0);
        chk("rst_udo",    user_data_out, 128'h0);
        chk("rst_strobe", 128'(user_wr_strobe), 128'h0);
        OPB_Rst = 1'b0;
        mon_en  = 1'b1;
        @(negedge clk);

        // Addresses just outside the window get no response at all.
        acks = 0;
        OPB_ABus = 32'h010B2200; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (Sl_xferAck) acks++;
        end
        OPB_ABus = 32'h010B20FC; OPB_RNW = 1'b0; OPB_DBus = 32'hFFFFFFFF;
        repeat (4) begin
            @(negedge clk);
            if (Sl_xferAck) acks++;
        end
        bus_idle();
        chk("miss_no_ack", 128'(acks), 128'h0);
        chk("miss_no_write", user_data_out, 128'h0);
        chk("miss_no_strobe", 128'(user_wr_strobe), 128'h0);

        // Table of single transfers: ack latency, read data, GAP-cycle strobe/data, then settled state.
        foreach (vecs[n]) begin
            xfer(vecs[n].rnw, BASE + {24'h0, vecs[n].off}, vecs[n].be, vecs[n].wdata, rd, cyc);
            chk({vecs[n].name, ":ack_cycle"}, 128'(cyc), 128'(1));
            chk({vecs[n].name, ":rdata"}, 128'(rd), 128'(vecs[n].exp_rd));
            @(negedge clk);
            chk({vecs[n].name, ":gap_strobe"}, 128'(user_wr_strobe), 128'(vecs[n].exp_stb));
            chk({vecs[n].name, ":gap_udo"}, user_data_out, vecs[n].exp_udo);
            chk({vecs[n].name, ":gap_ack"}, 128'(Sl_xferAck), 128'h0);
            @(negedge clk);
            chk({vecs[n].name, ":idle_strobe"}, 128'(user_wr_strobe), 128'h0);
            chk({vecs[n].name, ":idle_udo"}, user_data_out, vecs[n].exp_udo & ~PULSE_UDO);
        end

        // Select held high across two transfers to 0x08: acks only in cycles 1 and 4.
        pat = 8'h00;
        OPB_ABus = BASE + 32'h08; OPB_RNW = 1'b1; OPB_BE = 4'hF; OPB_select = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            pat[c-1] = Sl_xferAck;
            if (c == 6) bus_idle();
        end
        chk("held_select_ack_pattern", 128'(pat), 128'(8'b0000_1001));

        // Reset arriving in the ACK cycle of a write to reg0 discards the write.
        OPB_ABus = BASE; OPB_RNW = 1'b0; OPB_BE = 4'hF; OPB_DBus = 32'hFFFFFFFF; OPB_select = 1'b1;
        @(negedge clk);
        chk("rst_in_ack:ack_seen", 128'(Sl_xferAck), 128'h1);
        OPB_Rst = 1'b1;
        bus_idle();
        @(negedge clk);
        chk("rst_in_ack:ack", 128'(Sl_xferAck), 128'h0);
        chk("rst_in_ack:strobe", 128'(user_wr_strobe), 128'h0);
        chk("rst_in_ack:reg0", 128'(user_data_out[31:0]), 128'h0);
        OPB_Rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ack:strobe_after", 128'(user_wr_strobe), 128'h0);
        chk("rst_in_ack:udo_after", user_data_out, 128'h0);
        xfer(1'b1, BASE, 4'hF, 32'h0, rd, cyc);
        chk("rst_in_ack:read_ack", 128'(cyc), 128'(1));
        chk("rst_in_ack:read_reg0", 128'(rd), 128'h0);
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/opb_reg_bank_ppc2simulink.md
Name: opb_reg_bank_ppc2simulink

Overview:
Parametrised OPB slave holding NUM_REGS software-writable 32-bit control registers and NUM_STATUS read-only status words for the user fabric. It generalises the single-register PPC-to-Simulink bridge with:
- multiple registers in one address window;
- byte-enable writes and readback;
- per-register write strobes;
- an optional self-clearing pulse mode for start/arm triggers.

It sits on the OPB bus in the ROACH base system next to the existing single-register bridges. Everything runs on OPB_Clk.

Parameters:
C_BASEADDR, 32'h010B2100, base byte address of the window.
C_HIGHADDR, 32'h010B21FF, last byte address of the window.
C_OPB_AWIDTH, 32, OPB address width.
C_OPB_DWIDTH, 32, OPB data width; only 32 is supported.
C_FAMILY, "virtex5", target family; passed through only.
NUM_REGS, 4, number of control registers, 1..16.
NUM_STATUS, 2, number of status words, 0..16.
PULSE_MASK, 16'h0000, bit i=1 makes control register i self-clearing.

Ports:
OPB_Clk  in  1  sole clock
OPB_Rst  in  1  synchronous reset, active-high
OPB_ABus  in  [0:31]  address
OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7]
OPB_DBus  in  [0:31]  write data
OPB_RNW  in  1  1=read, 0=write
OPB_select  in  1  transfer request
OPB_seqAddr  in  1  ignored
Sl_DBus  out  [0:31]  read data; zero unless Sl_xferAck=1
Sl_xferAck  out  1  transfer acknowledge
Sl_errAck  out  1  tied 0
Sl_retry  out  1  tied 0
Sl_toutSup  out  1  tied 0
user_data_out  out  NUM_REGS*32  register i at bits [32*i+31:32*i]
user_wr_strobe  out  NUM_REGS  one-cycle pulse per register written
user_status_in  in  max(NUM_STATUS,1)*32  status word j at bits [32*j+31:32*j]

Behaviour:
- Reset is synchronous on OPB_Rst=1. While asserted:
  - state goes to IDLE;
  - Sl_xferAck=0, Sl_DBus=0;
  - all control registers = 0;
  - user_wr_strobe=0.
- Bit order: OPB bit k maps to user bit 31-k. OPB_BE[b] enables user bits [31-8b : 24-8b].
- Hit condition: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Offset = OPB_ABus[24:29] (word index).
- Address map, byte offset from base:
  - 0x00+4i: control register i, RW, for i<NUM_REGS.
  - 0x40+4j: status word j, RO, for j<NUM_STATUS.
  - Any other offset: reads 0, writes ignored, still acked. No errAck is ever raised.
- State machine IDLE -> ACK -> GAP -> IDLE:
  - IDLE: on hit, register RNW, offset, BE and DBus, and go to ACK. If read, also register Sl_DBus from the register/status value sampled at this edge.
  - ACK: Sl_xferAck=1 for exactly this cycle. Sl_DBus holds read data, or 0 for writes. A write is applied at the end of this cycle. Go to GAP.
  - GAP: Sl_xferAck=0, hits ignored, go to IDLE. This absorbs OPB_select lingering one cycle after the ack, so no double transfer occurs.
- Latency: select sampled at edge N; xferAck is high in cycle N..N+1. Minimum spacing between acks is 3 cycles.
- Write update:
  - Enabled bytes of the addressed register update at the edge ending ACK; bytes with BE=0 keep their value.
  - user_wr_strobe[i]=1 for the single GAP cycle, even if BE=0000.
  - New data is visible on user_data_out in the same cycle as the strobe.
- Pulse mode (PULSE_MASK[i]=1):
  - Register i shows the written value for exactly the GAP cycle, then returns to 0.
  - Readback of register i returns 0 outside that cycle.
- Status words are sampled at the IDLE->ACK edge with no synchronisation (user logic is on OPB_Clk).
- Reset during ACK or GAP: next cycle IDLE, xferAck=0. Any pending write is discarded and no strobe is issued.
- A miss (address outside window) produces no response. All slave outputs stay 0.

Test Plan:
- Reset, then read offsets 0x00..0x0C -> each ack returns 0x00000000; Sl_errAck/Sl_retry/Sl_toutSup stay 0 throughout.
- Write 0xDEADBEEF to 0x04 with BE=1111 -> xferAck on the 2nd cycle; user_wr_strobe=0010 for 1 cycle; user_data_out[63:32]=0xDEADBEEF; readback of 0x04 = 0xDEADBEEF.
- Reg0=0x11223344, then write 0xAABBCCDD with BE=0101 -> reg0=0x11BB33DD.
- PULSE_MASK=0001, write 0x1 to 0x00 -> user_data_out[31:0]=1 for exactly one cycle coincident with strobe[0], then 0.
- user_status_in word1=0x0000CAFE, read 0x44 -> 0x0000CAFE. Read 0x50 -> 0 and acked. A write to 0x44 changes no register and pulses no strobe.
- OPB_select held high 4 cycles to 0x08, then a back-to-back second transfer -> exactly one ack per 3-cycle window. Separately, OPB_Rst asserted in the ACK cycle of a write to 0x00 -> no strobe; reg0 = 0.
